iter_alu: RTL
=============

Name: iter_alu

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Keeps the full single-cycle op set, with registered outputs.
- Adds iterative multiply/divide (signed and unsigned) with internal HI/LO registers, plus MFHI/MFLO reads.
- Sits in the EX stage. The pipeline stalls on busy and captures the result on result_valid.

Parameters:
- WIDTH, 32, operand/result width (>=8, even).
- CTRL_W, 5, alu_control width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  operation request, sampled when busy=0
- alu_control  in  CTRL_W  opcode
- operand_A  in  WIDTH  first operand / shift amount
- operand_B  in  WIDTH  second operand / shifted value
- busy  out  1  high while an iterative op is in progress
- result_valid  out  1  one-cycle pulse when result/flags are valid
- result  out  WIDTH  registered result
- z_flag  out  1  zero flag
- n_flag  out  1  negative flag
- div0  out  1  set with result_valid when a DIV/DIVU divisor was 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, result_valid=0, result=0, z_flag=0, n_flag=0, div0=0; HI=LO=0; counter=0.
- Opcodes 0x00-0x0C, single-cycle; result, z and n follow the existing ALU definitions:
  - 0x00 add; 0x01 sub; 0x02 and; 0x03 or; 0x04 xor; 0x05 nor.
  - 0x06 sll B by A[CNT_W-2:0]; 0x07 srl; 0x08 sra.
  - 0x09 unsigned set-less-than; 0x0A pass A; 0x0B pass B; 0x0C B+8.
  - Flags: z/n computed from result for add, sub, pass A, pass B and +8. For slt, z=(result==0) and n=0. For all logic and shift ops, z=n=0.
- Iterative and HI/LO opcodes:
  - 0x0D MULTU, 0x0E MULT: {HI,LO} = A*B.
  - 0x0F DIVU, 0x10 DIV: LO = quotient, HI = remainder.
  - 0x11 MFHI, 0x12 MFLO: result = HI/LO; z/n computed from result.
  - Undefined opcodes: result=0, flags 0.
- Handshake:
  - start is accepted only in IDLE. Start while busy=1 is ignored with no side effects.
  - Single-cycle ops: accepted at edge k; result/flags/result_valid registered at edge k; result_valid deasserts at edge k+1 unless a new start arrives.
  - result and flags hold their value until the next accepted op completes.
- FSM states IDLE, MUL, DIV, FIX:
  - IDLE + start + mul op -> MUL. Latch |A|,|B| (MULT) or raw values (MULTU) and the sign bits; busy=1; cnt=0.
  - MUL: one shift-add per cycle. After WIDTH iterations (cnt==WIDTH-1) -> FIX.
  - IDLE + start + div op -> DIV, latched the same way.
  - DIV: restoring division, one quotient bit per cycle, WIDTH cycles -> FIX.
  - FIX:
    - MULT: negate the 2*WIDTH product if signs differ.
    - DIV: negate the quotient if signs differ; the remainder takes the dividend's sign.
    - Write HI/LO; result=LO; z=n=0; result_valid=1; busy=0; -> IDLE.
  - Latency: start accepted at edge k -> result_valid registered at edge k+WIDTH+1, i.e. busy high for WIDTH+1 cycles.
- Boundary conditions:
  - Divisor 0: still runs the full WIDTH+1 cycles. LO = all ones, HI = dividend, div0=1 with the valid pulse.
  - DIV with the most negative value / -1: LO = most negative value (wrap), HI=0, div0=0.
  - Shift amounts >= WIDTH are impossible: only the low CNT_W-1 bits are used.
  - rst_n asserted mid-iteration: immediate abort to IDLE with all reset values; HI/LO cleared.
  - MFHI/MFLO issued directly after the valid pulse of MULT/DIV returns the new HI/LO.

Decomposition:
- Shared package alu_pkg:
  - opcode localparams (ALU_ADD .. ALU_MFLO, CTRL_W=5);
  - FSM state encoding (IDLE, MUL, DIV, FIX, 2 bits).
- One sub-module, alu_comb: the existing single-cycle op/flag logic, parametrised by WIDTH. It is instantiated inside iter_alu, and its outputs are registered on the single-cycle path.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 -> all outputs 0, busy=0; MFHI returns 0.
- ADD: start, A=0xFFFFFFFF, B=1 -> next edge result=0, z=1, n=0, result_valid pulses exactly 1 cycle. SUB 3-5 -> 0xFFFFFFFE, n=1.
- MULT: A=-3 (0xFFFFFFFD), B=7 -> busy high for 33 cycles; result_valid at cycle 33; LO=0xFFFFFFEB, MFHI=0xFFFFFFFF. MULTU same operands -> HI=0x00000006, LO=0xFFFFFFEB.
- DIV: A=-7, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100/7 -> LO=14, HI=2.
- DIVU by 0: A=0x1234, B=0 -> after 33 cycles div0=1, LO=0xFFFFFFFF, MFHI=0x1234. Start pulsed during busy -> ignored, latency unchanged.
- Reset mid-MULT at cycle 10 -> busy=0, result_valid never pulses, HI=LO=0. Repeat the MULT test at WIDTH=16 -> valid after 17 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and opcode-class helpers for the
// iterative ALU and its single-cycle combinational core.
package alu_pkg;

  localparam int ALU_CTRL_W = 5;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = 5'h00;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = 5'h01;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND   = 5'h02;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR    = 5'h03;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = 5'h04;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR   = 5'h05;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = 5'h06;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = 5'h07;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = 5'h08;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = 5'h09;
  localparam logic [ALU_CTRL_W-1:0] ALU_PASSA = 5'h0A;
  localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = 5'h0B;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD8  = 5'h0C;
  localparam logic [ALU_CTRL_W-1:0] ALU_MULTU = 5'h0D;
  localparam logic [ALU_CTRL_W-1:0] ALU_MULT  = 5'h0E;
  localparam logic [ALU_CTRL_W-1:0] ALU_DIVU  = 5'h0F;
  localparam logic [ALU_CTRL_W-1:0] ALU_DIV   = 5'h10;
  localparam logic [ALU_CTRL_W-1:0] ALU_MFHI  = 5'h11;
  localparam logic [ALU_CTRL_W-1:0] ALU_MFLO  = 5'h12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  function automatic logic is_mul_op(input logic [ALU_CTRL_W-1:0] op);
    return (op == ALU_MULTU) || (op == ALU_MULT);
  endfunction

  function automatic logic is_div_op(input logic [ALU_CTRL_W-1:0] op);
    return (op == ALU_DIVU) || (op == ALU_DIV);
  endfunction

  function automatic logic is_signed_op(input logic [ALU_CTRL_W-1:0] op);
    return (op == ALU_MULT) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU core: result and z/n flags for opcodes 0x00-0x0C.
// Any other opcode yields a zero result with both flags clear.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [ALU_CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]      operand_A,
  input  logic [WIDTH-1:0]      operand_B,
  output logic [WIDTH-1:0]      result,
  output logic                  z_flag,
  output logic                  n_flag
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] shamt;
  logic            a_lt_b;
  logic            flag_en;

  assign shamt  = operand_A[SH_W-1:0];
  assign a_lt_b = operand_A < operand_B;

  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    result  = '0;
    z_flag  = 1'b0;
    n_flag  = 1'b0;
    flag_en = 1'b0;
    case (alu_control)
      ALU_ADD:   begin result = operand_A + operand_B;  flag_en = 1'b1; end
      ALU_SUB:   begin result = operand_A - operand_B;  flag_en = 1'b1; end
      ALU_AND:   result = operand_A & operand_B;
      ALU_OR:    result = operand_A | operand_B;
      ALU_XOR:   result = operand_A ^ operand_B;
      ALU_NOR:   result = ~(operand_A | operand_B);
      ALU_SLL:   result = operand_B << shamt;
      ALU_SRL:   result = operand_B >> shamt;
      ALU_SRA:   result = $signed(operand_B) >>> shamt;
      ALU_SLTU: begin
        result = {{(WIDTH-1){1'b0}}, a_lt_b};
        z_flag = ~a_lt_b;
      end
      ALU_PASSA: begin result = operand_A;              flag_en = 1'b1; end
      ALU_PASSB: begin result = operand_B;              flag_en = 1'b1; end
      ALU_ADD8:  begin result = operand_B + WIDTH'(8);  flag_en = 1'b1; end
      default:   result = '0;
    endcase
    // Arithmetic and pass ops derive both flags from the result itself.
    if (flag_en) begin
      z_flag = (result == '0);
      n_flag = result[WIDTH-1];
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle EX-stage ALU: registered single-cycle ops plus iterative
// shift-add multiply and restoring divide into internal HI/LO registers.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]  operand_A,
  input  logic [WIDTH-1:0]  operand_B,
  output logic              busy,
  output logic              result_valid,
  output logic [WIDTH-1:0]  result,
  output logic              z_flag,
  output logic              n_flag,
  output logic              div0
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]      acc_q, acc_d;
  logic [WIDTH-1:0]        opnd_q, opnd_d;
  logic                    neg_lo_q, neg_lo_d;
  logic                    neg_hi_q, neg_hi_d;
  logic                    dz_q, dz_d;
  logic                    op_div_q, op_div_d;
  logic [WIDTH-1:0]        hi_q, hi_d;
  logic [WIDTH-1:0]        lo_q, lo_d;
  logic [WIDTH-1:0]        result_q, result_d;
  logic                    z_q, z_d;
  logic                    n_q, n_d;
  logic                    div0_q, div0_d;
  logic                    valid_q, valid_d;

  logic [ALU_CTRL_W-1:0]   op;
  logic [WIDTH-1:0]        comb_result;
  logic                    comb_z, comb_n;
  logic                    accept, last_iter, op_mul, op_div, op_sgn;
  logic [WIDTH-1:0]        mag_a, mag_b, hilo_sel;
  logic [WIDTH:0]          mul_sum, rem_sh;
  logic                    div_ge;
  logic [WIDTH-1:0]        rem_next;
  logic [2*WIDTH-1:0]      prod_fix;
  logic [WIDTH-1:0]        fix_hi, fix_lo;

  assign op        = ALU_CTRL_W'(alu_control);
  assign accept    = start && (state_q == ST_IDLE);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign op_mul    = is_mul_op(op);
  assign op_div    = is_div_op(op);
  assign op_sgn    = is_signed_op(op);
  assign mag_a     = (op_sgn && operand_A[WIDTH-1]) ? -operand_A : operand_A;
  assign mag_b     = (op_sgn && operand_B[WIDTH-1]) ? -operand_B : operand_B;
  assign hilo_sel  = (op == ALU_MFHI) ? hi_q : lo_q;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .alu_control (op),
    .operand_A   (operand_A),
    .operand_B   (operand_B),
    .result      (comb_result),
    .z_flag      (comb_z),
    .n_flag      (comb_n)
  );

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge   = rem_sh >= {1'b0, opnd_q};
  assign rem_next = div_ge ? (rem_sh[WIDTH-1:0] - opnd_q) : rem_sh[WIDTH-1:0];

  always_comb begin
    prod_fix = neg_lo_q ? -acc_q : acc_q;
    if (op_div_q) begin
      fix_lo = dz_q ? '1 : (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
      fix_hi = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end else begin
      fix_lo = prod_fix[WIDTH-1:0];
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // State register.
  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && op_mul)      state_d = ST_MUL;
        else if (accept && op_div) state_d = ST_DIV;
      end
      ST_MUL:  if (last_iter) state_d = ST_FIX;
      ST_DIV:  if (last_iter) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are taken straight from registers.
  always_comb begin
    busy         = (state_q != ST_IDLE);
    result_valid = valid_q;
    result       = result_q;
    z_flag       = z_q;
    n_flag       = n_q;
    div0         = div0_q;
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    op_div_d = op_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    div0_d   = div0_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_mul || op_div) begin
            cnt_d    = '0;
            opnd_d   = op_mul ? mag_a : mag_b;
            acc_d    = {{WIDTH{1'b0}}, (op_mul ? mag_b : mag_a)};
            neg_lo_d = op_sgn && (operand_A[WIDTH-1] ^ operand_B[WIDTH-1]);
            neg_hi_d = op_sgn && operand_A[WIDTH-1];
            dz_d     = (operand_B == '0);
            op_div_d = op_div;
          end else if ((op == ALU_MFHI) || (op == ALU_MFLO)) begin
            result_d = hilo_sel;
            z_d      = (hilo_sel == '0);
            n_d      = hilo_sel[WIDTH-1];
            div0_d   = 1'b0;
            valid_d  = 1'b1;
          end else begin
            result_d = comb_result;
            z_d      = comb_z;
            n_d      = comb_n;
            div0_d   = 1'b0;
            valid_d  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
      end
      ST_DIV: begin
        acc_d = {rem_next, acc_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + CNT_W'(1);
      end
      ST_FIX: begin
        hi_d     = fix_hi;
        lo_d     = fix_lo;
        result_d = fix_lo;
        z_d      = 1'b0;
        n_d      = 1'b0;
        div0_d   = op_div_q && dz_q;
        valid_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      op_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      div0_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      op_div_q <= op_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      div0_q   <= div0_d;
      valid_q  <= valid_d;
    end
  end

endmodule
